// File: rtl/if_id_hazard_ctrl.sv
// IF/ID + PC sequencer: load-use stalls, taken-branch flushes, mult/div occupancy; saturating perf counters.
// Outputs are combinational from inputs and state (zero latency); stalls are the backpressure, pc_we/if_id_we drop together.
module if_id_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN, S_MD_WAIT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_LAT - 2);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_wait_cnt, w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt;
  logic       w_uses_rt, w_lu;
  logic       w_pc_we, w_if_id_we, w_flush, w_bubble, w_busy;
  logic       w_unused;

  assign w_op      = id_instr[31:26];
  assign w_rs      = id_instr[25:21];
  assign w_rt      = id_instr[20:16];
  assign w_unused  = ^id_instr[15:0];
  assign w_uses_rt = (w_op == 6'h00) || (w_op == 6'h04) || (w_op == 6'h05) || (w_op == 6'h2B);
  assign w_lu      = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == w_rs) || (w_uses_rt && (ex_rt == w_rt)));

  always_comb begin
    w_pc_we        = 1'b1;
    w_if_id_we     = 1'b1;
    w_flush        = 1'b0;
    w_bubble       = 1'b0;
    w_busy         = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (muldiv_start) begin
          w_pc_we    = 1'b0;
          w_if_id_we = 1'b0;
          w_bubble   = 1'b1;
          // With MULDIV_LAT==2 the single RUN-cycle stall is the whole occupancy.
          if (MULDIV_LAT > 2) begin
            w_state_nxt    = S_MD_WAIT;
            w_wait_cnt_nxt = WAIT_LOAD;
          end
        end else if (w_lu) begin
          w_pc_we    = 1'b0;
          w_if_id_we = 1'b0;
          w_bubble   = 1'b1;
        end
      end
      S_MD_WAIT: begin
        w_busy         = 1'b1;
        w_pc_we        = 1'b0;
        w_if_id_we     = 1'b0;
        w_bubble       = 1'b1;
        w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        // Counter holds remaining wait cycles including this one.
        if (r_wait_cnt <= 4'd1) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign pc_we        = rst_n & w_pc_we;
  assign if_id_we     = rst_n & w_if_id_we;
  assign if_id_flush  = ~rst_n | w_flush;
  assign id_ex_bubble = ~rst_n | w_bubble;
  assign busy         = rst_n & w_busy;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl: vector table in RUN plus mult/div, async reset and saturation sequences.
module tb_if_id_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        muldiv_start;

  logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_bubble, s_busy;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  if_id_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .busy(s_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mr;
    logic [4:0]  rt;
    logic [31:0] instr;
    logic        br;
    logic        md;
    logic [3:0]  exp;   // {pc_we, if_id_we, if_id_flush, id_ex_bubble}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rt, input logic [31:0] instr,
                       input logic br, input logic md);
    ex_mem_read  = mr;
    ex_rt        = rt;
    id_instr     = instr;
    branch_taken = br;
    muldiv_start = md;
  endtask

  task automatic chk_ctrl(input string name, input logic [3:0] exp, input logic exp_busy);
    chk({name, "_ctrl"}, {28'd0, pc_we, if_id_we, if_id_flush, id_ex_bubble}, {28'd0, exp});
    chk({name, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
  endtask

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"idle",        1'b0, 5'd0,  32'h00000000, 1'b0, 1'b0, 4'b1100};
    vecs[1] = '{"lu_add_rs",   1'b1, 5'd8,  32'h01094020, 1'b0, 1'b0, 4'b0001};
    vecs[2] = '{"lu_rt0",      1'b1, 5'd0,  32'h00004020, 1'b0, 1'b0, 4'b1100};
    vecs[3] = '{"lw_rt_only",  1'b1, 5'd9,  32'h8D490000, 1'b0, 1'b0, 4'b1100};
    vecs[4] = '{"sw_rt",       1'b1, 5'd9,  32'hAD490000, 1'b0, 1'b0, 4'b0001};
    vecs[5] = '{"beq_rt",      1'b1, 5'd9,  32'h11490000, 1'b0, 1'b0, 4'b0001};
    vecs[6] = '{"lw_rs",       1'b1, 5'd10, 32'h8D490000, 1'b0, 1'b0, 4'b0001};
    vecs[7] = '{"no_memread",  1'b0, 5'd8,  32'h01094020, 1'b0, 1'b0, 4'b1100};
    vecs[8] = '{"br_wins",     1'b1, 5'd8,  32'h01094020, 1'b1, 1'b1, 4'b1111};
    vecs[9] = '{"br_only",     1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 4'b1111};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    chk_ctrl("reset", 4'b0011, 1'b0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_ctrl("first_run", 4'b1100, 1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].mr, vecs[i].rt, vecs[i].instr, vecs[i].br, vecs[i].md);
      #2;
      chk({vecs[i].name, "_stall_cnt"}, {16'd0, stall_cnt}, m_stall);
      chk({vecs[i].name, "_flush_cnt"}, {16'd0, flush_cnt}, m_flush);
      chk_ctrl(vecs[i].name, vecs[i].exp, 1'b0);
      if (!vecs[i].exp[3]) m_stall++;
      if (vecs[i].exp[1])  m_flush++;
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #2;
    chk_ctrl("post_table", 4'b1100, 1'b0);
    chk("post_table_stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("post_table_flush_cnt", {16'd0, flush_cnt}, m_flush);

    // mult/div: 3 stalled cycles, busy on the last two, branch ignored while busy
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #2;
    chk_ctrl("md_c1", 4'b0001, 1'b0);
    m_stall++;
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #2;
    chk_ctrl("md_c2_br", 4'b0001, 1'b1);
    m_stall++;
    @(negedge clk);
    #2;
    chk_ctrl("md_c3_br", 4'b0001, 1'b1);
    m_stall++;
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #2;
    chk_ctrl("md_resume", 4'b1100, 1'b0);
    chk("md_stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("md_flush_cnt", {16'd0, flush_cnt}, m_flush);

    // asynchronous reset in the second MD_WAIT cycle
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("mdrst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_ctrl("mdrst_async", 4'b0011, 1'b0);
    chk("mdrst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mdrst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("mdrst_sat_stall_cnt", {28'd0, s_stall_cnt}, 32'd0);
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_ctrl("mdrst_release", 4'b1100, 1'b0);

    // saturation: continuous load-use stall
    @(negedge clk);
    drive(1'b1, 5'd8, 32'h01094020, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #2;
    chk("sat_main_14", {16'd0, stall_cnt}, 32'd14);
    chk("sat_small_14", {28'd0, s_stall_cnt}, 32'd14);
    repeat (6) @(negedge clk);
    #2;
    chk("sat_main_20", {16'd0, stall_cnt}, 32'd20);
    chk("sat_small_20", {28'd0, s_stall_cnt}, 32'd15);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    chk("sat_main_hold", {16'd0, stall_cnt}, 32'd21);
    chk("sat_small_hold", {28'd0, s_stall_cnt}, 32'd15);
    chk("sat_small_flush", {28'd0, s_flush_cnt}, 32'd0);
    chk_ctrl("sat_end", 4'b1100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
